// File: rtl/sad_block_buffer_if.sv
// Write stream and read port shared between the SAD block buffer and its clients.
// The master side is the writer/engine; the slave side is the buffer itself.
interface sad_block_buffer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_a;
  logic [DATA_W-1:0] wr_b;
  logic [ADDR_W-1:0] AB_addr;
  logic [DATA_W-1:0] A_data;
  logic [DATA_W-1:0] B_data;

  modport master (
    output wr_valid, wr_a, wr_b, AB_addr,
    input  wr_ready, A_data, B_data
  );

  modport slave (
    input  wr_valid, wr_a, wr_b, AB_addr,
    output wr_ready, A_data, B_data
  );
endinterface

// File: rtl/sad_block_buffer.sv
// Dual pixel-block buffer: loads blocks A/B from a pixel-pair stream, pulses go
// when full, serves combinational reads and holds contents until sad_done.
module sad_block_buffer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              Mrst_n,
  sad_block_buffer_if.slave bus,
  input  logic              clr,
  input  logic              sad_done,
  output logic              go,
  output logic [ADDR_W-1:0] wr_count,
  output logic [1:0]        state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_count_q, wr_count_d;
  logic              wr_fire;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_in_range;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  // clr wins over a simultaneous write, so the dropped pair never reaches memory
  assign wr_fire = bus.wr_valid && (state_q == S_LOAD) && !clr;
  assign wr_idx  = wr_count_q[IDX_W-1:0];

  always_ff @(posedge clk or negedge Mrst_n) begin
    if (!Mrst_n) begin
      state_q    <= S_LOAD;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    if (clr) begin
      state_d    = S_LOAD;
      wr_count_d = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (bus.wr_valid) begin
            wr_count_d = wr_count_q + ADDR_W'(1);
            if (wr_count_q == LAST_A) state_d = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_HOLD;
        S_HOLD: begin
          if (sad_done) begin
            state_d    = S_LOAD;
            wr_count_d = '0;
          end
        end
        default: begin
          state_d    = S_LOAD;
          wr_count_d = '0;
        end
      endcase
    end
  end

  // Handshake outputs depend on state only, keeping the writer free of loops
  always_comb begin
    bus.wr_ready = (state_q == S_LOAD);
    go           = (state_q == S_ISSUE);
  end

  assign wr_count = wr_count_q;
  assign state    = state_q;

  // Storage: data arrays carry no reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_a[wr_idx] <= bus.wr_a;
      mem_b[wr_idx] <= bus.wr_b;
    end
  end

  assign rd_in_range = (bus.AB_addr < DEPTH_A);
  assign rd_idx      = bus.AB_addr[IDX_W-1:0];

  always_comb begin
    bus.A_data = '0;
    bus.B_data = '0;
    if (rd_in_range) begin
      bus.A_data = mem_a[rd_idx];
      bus.B_data = mem_b[rd_idx];
    end
  end

endmodule

// File: tb/tb_sad_block_buffer.sv
// Bench for sad_block_buffer: directed sequences, a read-vector table and a
// randomized run checked cycle by cycle against a behavioural model.
module tb_sad_block_buffer;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              Mrst_n;
  logic              clr;
  logic              sad_done;
  logic              go;
  logic [ADDR_W-1:0] wr_count;
  logic [1:0]        state;

  sad_block_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  sad_block_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .Mrst_n   (Mrst_n),
    .bus      (bus),
    .clr      (clr),
    .sad_done (sad_done),
    .go       (go),
    .wr_count (wr_count),
    .state    (state)
  );

  typedef struct {
    int addr;
    int exp_a;
    int exp_b;
  } rd_vec_t;

  int n_checks = 0;
  int n_err    = 0;
  int go_seen  = 0;

  // Model: phase 0 loading, 1 issuing, 2 holding; count of pairs this load
  int mdl_phase;
  int mdl_cnt;
  int mdl_a [DEPTH];
  int mdl_b [DEPTH];
  bit mdl_wr[DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int ad;
    ad = int'(bus.AB_addr);
    chk("state", 32'(state), mdl_phase);
    chk("wr_count", 32'(wr_count), mdl_cnt);
    chk("go", 32'(go), 32'(mdl_phase == 1));
    chk("wr_ready", 32'(bus.wr_ready), 32'(mdl_phase == 0));
    if (ad >= DEPTH) begin
      chk("A_data_oor", 32'(bus.A_data), 0);
      chk("B_data_oor", 32'(bus.B_data), 0);
    end else if (mdl_wr[ad]) begin
      chk("A_data", 32'(bus.A_data), mdl_a[ad]);
      chk("B_data", 32'(bus.B_data), mdl_b[ad]);
    end
    if (go === 1'b1) go_seen++;
  endtask

  task automatic step(input bit v, input int a, input int b, input bit c, input bit d, input int addr);
    bus.wr_valid = v;
    bus.wr_a     = DATA_W'(a);
    bus.wr_b     = DATA_W'(b);
    clr          = c;
    sad_done     = d;
    bus.AB_addr  = ADDR_W'(addr);
    @(posedge clk);
    if (c) begin
      mdl_phase = 0;
      mdl_cnt   = 0;
    end else if (mdl_phase == 0) begin
      if (v) begin
        mdl_a[mdl_cnt]  = a & 255;
        mdl_b[mdl_cnt]  = b & 255;
        mdl_wr[mdl_cnt] = 1'b1;
        mdl_cnt++;
        if (mdl_cnt == DEPTH) mdl_phase = 1;
      end
    end else if (mdl_phase == 1) begin
      mdl_phase = 2;
    end else if (d) begin
      mdl_phase = 0;
      mdl_cnt   = 0;
    end
    #1 check_outputs();
  endtask

  rd_vec_t tbl[6];

  initial begin
    tbl[0] = '{addr: 10,  exp_a: 10,  exp_b: 245};
    tbl[1] = '{addr: 255, exp_a: 255, exp_b: 0};
    tbl[2] = '{addr: 0,   exp_a: 0,   exp_b: 255};
    tbl[3] = '{addr: 300, exp_a: 0,   exp_b: 0};
    tbl[4] = '{addr: 256, exp_a: 0,   exp_b: 0};
    tbl[5] = '{addr: 511, exp_a: 0,   exp_b: 0};

    for (int i = 0; i < DEPTH; i++) mdl_wr[i] = 1'b0;
    Mrst_n       = 1'b0;
    clr          = 1'b0;
    sad_done     = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_a     = '0;
    bus.wr_b     = '0;
    bus.AB_addr  = '0;
    mdl_phase    = 0;
    mdl_cnt      = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(wr_count), 0);
    chk("rst_ready", 32'(bus.wr_ready), 1);
    chk("rst_go", 32'(go), 0);
    @(negedge clk) Mrst_n = 1'b1;

    // Ramp load
    go_seen = 0;
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, 255 - i, 1'b0, 1'b0, i);
    chk("ramp_go_after_last", 32'(go), 1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 10);
    chk("ramp_go_pulses", go_seen, 1);
    chk("ramp_state_hold", 32'(state), 2);

    // Read-vector table in HOLD
    for (int k = 0; k < 6; k++) begin
      bus.AB_addr = ADDR_W'(tbl[k].addr);
      #1;
      chk("tbl_A", 32'(bus.A_data), tbl[k].exp_a);
      chk("tbl_B", 32'(bus.B_data), tbl[k].exp_b);
    end

    // Backpressure in HOLD
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 255, 255, 1'b0, 1'b0, 0);
      chk("bp_ready", 32'(bus.wr_ready), 0);
      chk("bp_count", 32'(wr_count), 256);
      chk("bp_A0", 32'(bus.A_data), 0);
    end

    // Release and reload with constant pattern
    step(1'b0, 0, 0, 1'b0, 1'b1, 0);
    chk("rel_count", 32'(wr_count), 0);
    chk("rel_ready", 32'(bus.wr_ready), 1);
    go_seen = 0;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 'h55, 'hAA, 1'b0, 1'b0, i);
    step(1'b0, 0, 0, 1'b0, 1'b0, 0);
    chk("reload_go_pulses", go_seen, 1);
    for (int i = 0; i < DEPTH; i++) begin
      bus.AB_addr = ADDR_W'(i);
      #1;
      chk("reload_A", 32'(bus.A_data), 'h55);
      chk("reload_B", 32'(bus.B_data), 'hAA);
    end

    // Soft clear after 100 accepts, with a simultaneous write
    step(1'b0, 0, 0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 100; i++) step(1'b1, 'h33, 'hCC, 1'b0, 1'b0, i);
    step(1'b1, 'h77, 'h77, 1'b1, 1'b0, 100);
    chk("clr_count", 32'(wr_count), 0);
    chk("clr_dropped_A100", 32'(bus.A_data), 'h55);
    go_seen = 0;
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 'h33, 'hCC, 1'b0, 1'b0, i);
    chk("clr_no_early_go", go_seen, 0);
    chk("clr_count_255", 32'(wr_count), 255);
    step(1'b1, 'h33, 'hCC, 1'b0, 1'b0, 255);
    chk("clr_go_on_256th", go_seen, 1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 0);

    // Async reset mid-cycle while in HOLD
    #2 Mrst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_count", 32'(wr_count), 0);
    chk("arst_ready", 32'(bus.wr_ready), 1);
    mdl_phase = 0;
    mdl_cnt   = 0;
    @(posedge clk);
    @(negedge clk) Mrst_n = 1'b1;
    go_seen = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, 1'b0, 1'b0, i);
    chk("arst_no_go", go_seen, 0);

    // sad_done in LOAD is ignored; out-of-range read
    for (int i = 0; i < 5; i++) step(1'b1, i + 1, i + 2, 1'b0, 1'b0, i);
    step(1'b0, 0, 0, 1'b0, 1'b1, 300);
    chk("done_in_load_count", 32'(wr_count), 5);
    chk("range_A300", 32'(bus.A_data), 0);
    chk("range_B300", 32'(bus.B_data), 0);

    // Randomized run against the model
    for (int n = 0; n < 4000; n++) begin
      step(($urandom % 10) < 7, int'($urandom % 256), int'($urandom % 256),
           ($urandom % 1500) == 0, ($urandom % 6) == 0, int'($urandom % 512));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
